// File: rtl/bcd_updown_ctr.sv
// Up/down BCD counter driven by button-controller commands: manual stepping in SET,
// prescaled auto-count in RUN, frozen in PAUSE. Optional macro BCD_UPDOWN_CTR_SATURATE_EN.
module bcd_updown_ctr #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            stat,
    input  logic                  inc,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  dir,
    output logic                  running,
    output logic                  wrap
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_SET   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_PAUSE = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    mode_e          mode;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic           dir_q, dir_d;
    logic           running_q, running_d;
    logic           wrap_q, wrap_d;
    logic [PW-1:0]  presc_q, presc_d;

    logic [BW-1:0]  up_val, dn_val;
    logic           up_wrap, dn_wrap;
    logic           up_carry, dn_borrow;
    logic [PW-1:0]  presc_eff;
    logic           do_up, do_dn;

    assign mode = mode_e'(stat);

    // Ripple BCD increment/decrement of the current value.
    always_comb begin
        up_val    = bcd_q;
        dn_val    = bcd_q;
        up_carry  = 1'b1;
        dn_borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (up_carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    up_val[4*i +: 4] = 4'd0;
                end else begin
                    up_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    up_carry         = 1'b0;
                end
            end
            if (dn_borrow) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    dn_val[4*i +: 4] = 4'd9;
                end else begin
                    dn_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    dn_borrow        = 1'b0;
                end
            end
        end
`ifdef BCD_UPDOWN_CTR_SATURATE_EN
        if (up_carry) up_val = bcd_q;
        if (dn_borrow) dn_val = bcd_q;
        up_wrap = 1'b0;
        dn_wrap = 1'b0;
`else
        up_wrap = up_carry;
        dn_wrap = dn_borrow;
`endif
    end

    // Mode handling; RUN entry (previous mode not RUN) counts from a cleared prescaler.
    always_comb begin
        bcd_d     = bcd_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        wrap_d    = 1'b0;
        running_d = (mode == MODE_RUN);
        do_up     = 1'b0;
        do_dn     = 1'b0;
        presc_eff = running_q ? presc_q : '0;
        case (mode)
            MODE_SET: begin
                presc_d = '0;
                if (inc && !dec) begin
                    do_up = 1'b1;
                    dir_d = 1'b1;
                end else if (dec && !inc) begin
                    do_dn = 1'b1;
                    dir_d = 1'b0;
                end
            end
            MODE_RUN: begin
                if (presc_eff == PRE_LAST) begin
                    presc_d = '0;
                    do_up   = dir_q;
                    do_dn   = !dir_q;
                end else begin
                    presc_d = presc_eff + PW'(1);
                end
                if (inc && !dec) begin
                    dir_d = 1'b1;
                end else if (dec && !inc) begin
                    dir_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (do_up) begin
            bcd_d  = up_val;
            wrap_d = up_wrap;
        end else if (do_dn) begin
            bcd_d  = dn_val;
            wrap_d = dn_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            dir_q     <= 1'b1;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            presc_q   <= '0;
        end else begin
            bcd_q     <= bcd_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            presc_q   <= presc_d;
        end
    end

    assign bcd     = bcd_q;
    assign dir     = dir_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/bcd_updown_ctr.md
# bcd_updown_ctr

Consumer of the button-controller command outputs (`stat`, `dec`, `inc`). Holds a DIGITS-wide BCD value that is stepped manually by single-cycle `inc`/`dec` pulses in SET mode, or that auto-counts once per prescaled tick in RUN mode. In PAUSE mode the value is frozen. Sits between the button controller and the display driver, which reads `bcd`.

## Interface
- `TICK_DIV`, default 50000000: clocks per auto-count step. At 50 MHz this is 1 s. Legal range is ≥ 2.
- `DIGITS`, default 4: number of BCD digits. Legal range is 1-8.
- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stat` input 2: mode level. 0 = SET, 1 = RUN, 2 = PAUSE, 3 = treated as PAUSE.
- `inc` input 1: single-cycle step-up command.
- `dec` input 1: single-cycle step-down command.
- `bcd` output 4*DIGITS: current value; digit 0 is in [3:0]; registered.
- `dir` output 1: auto-count direction (1 = up); registered.
- `running` output 1: high while in RUN; registered.
- `wrap` output 1: one-cycle pulse when the value wraps; registered.

## Operation
- Reset (`rst_n`=0, immediate): `bcd`=0, `dir`=1, `running`=0, `wrap`=0, prescaler=0, internal previous-mode register = SET.
- Step up: add 1 with per-digit BCD carry; 9→0 carries into the next digit.
  - All digits 9 → all 0, and `wrap`=1 for that cycle.
- Step down: subtract 1 with per-digit borrow; 0→9 borrows from the next digit.
  - All digits 0 → all 9, and `wrap`=1 for that cycle.
- SET (`stat`=0):
  - `inc` alone → step up and set `dir`=1.
  - `dec` alone → step down and set `dir`=0.
  - `inc` and `dec` together → no step, `dir` unchanged.
  - Prescaler held at 0.
- RUN (`stat`=1):
  - Prescaler counts 0..TICK_DIV-1. When it reaches TICK_DIV-1 it returns to 0 and the value steps once in direction `dir`.
  - `inc`/`dec` do not step the value. They only update `dir` (same rules as SET, including simultaneous → unchanged).
- PAUSE (`stat`=2 or 3):
  - Value, `dir` and prescaler are all held.
  - `inc`/`dec` are ignored.
- Entry into RUN from any other mode clears the prescaler, so the first step is a full TICK_DIV period after entry.
- Leaving RUN holds the prescaler value. It is cleared again on the next RUN entry.
- `bcd` digits are always valid BCD (0-9). No input can produce A-F.

## Timing
- A command pulse in cycle N gives the updated `bcd`/`dir`/`wrap` in cycle N+1. Latency is 1.
- `stat` is sampled every cycle.
  - `running` follows `stat`==1 with 1-cycle latency.
  - A RUN→PAUSE change in cycle N blocks any tick step scheduled for cycle N.
- Auto-step: the prescaler reaches TICK_DIV-1 in cycle N → `bcd` changes in cycle N+1.
  - Steady-state step period is exactly TICK_DIV cycles.
- `wrap` is high for exactly 1 cycle per wrap event and is 0 in every other cycle.
- Reset asserted mid-count returns all outputs to their reset values at once. Counting resumes from 0 after release.

## Configuration
- Macro: `BCD_UPDOWN_CTR_SATURATE_EN`.
- Defined:
  - Step up at all-9 holds at all-9.
  - Step down at all-0 holds at all-0.
  - `wrap` is tied to 0.
  - All other behaviour is unchanged.
- Undefined: wrap-around as described in Operation.

## Test plan
All scenarios use TICK_DIV=4 and DIGITS=2.
- Reset, SET mode, 3 `inc` pulses, then 1 `dec` pulse → `bcd`=0x02, `dir`=0, `wrap` never high.
- SET mode, load 0x99, then one `inc` → `bcd`=0x00 with a 1-cycle `wrap`. With the macro defined → `bcd` stays 0x99 and `wrap`=0.
- SET mode from 0x00, `inc` and `dec` high in the same cycle → `bcd`=0x00 and `dir` unchanged.
- SET mode, `bcd`=0x08, `dir`=1, switch to RUN and hold 12 cycles → `bcd` steps at entry+4, +8 and +12 to reach 0x11. `running`=1 from entry+1.
- RUN mode with `dir`=1, pulse `dec`, then run 8 cycles → `dir`=0 and `bcd` drops by 2.
- RUN mode at 0x05, drop `rst_n` for 1 cycle mid-period → all outputs at reset values at once. After release, `bcd` stays 0x00 and `running` goes back to 1.
